hall_speed_meter: RTL and testbench
===================================

// Module: hall_speed_meter
// PURPOSE
//  Multi-wheel 3-phase hall-sensor commutation timer. It replaces the async
//  hall-edge speed logic with a fully synchronous measurement.
//  Per wheel it provides: sync+debounce, commutation decode, direction,
//  signed position, last commutation period, stall detect, error count.
//  Readable/writable over the Avalon slave, alongside the angle-sensor controller.
// PARAMETERS
//  CLOCK_SPEED_HZ   50_000_000  system clock frequency (documentation/tick sanity)
//  NUMBER_OF_WHEELS 1           independent hall triplets, 1..255
//  TICK_DIV         50          clocks per period tick (50 -> 1 us at 50 MHz)
//  PERIOD_WIDTH     24          period counter width in ticks
//  TIMEOUT_TICKS    1_000_000   ticks without valid edge -> stall, < 2**PERIOD_WIDTH
//  DEBOUNCE_CYCLES  16          consecutive equal samples to accept a hall bit
// PORTS
//  clock        in   1                     system clock
//  reset_n      in   1                     asynchronous, active-low reset
//  hall         in   3*NUMBER_OF_WHEELS    raw hall bits, wheel w = hall[3w+2:3w] = {h3,h2,h1}
//  address      in   16                    [15:8] register select, [7:0] wheel index
//  read         in   1                     Avalon read strobe
//  write        in   1                     Avalon write strobe
//  writedata    in   32                    Avalon write data (signed)
//  readdata     out  32                    Avalon read data
//  waitrequest  out  1                     Avalon wait
//  stall        out  NUMBER_OF_WHEELS      per-wheel stall flag
// BEHAVIOUR
//  Reset
//   - All state is cleared asynchronously on reset_n low.
//   - readdata=0, waitrequest=0, stall=all 1s.
//   - period=0, position=0, dir=0, err=0, accepted state=0.
//  Input conditioning
//   - Each hall bit passes a 2-FF synchronizer.
//   - A per-bit counter updates the debounced bit after DEBOUNCE_CYCLES consecutive
//     samples differing from it; any equal sample clears that counter.
//  Tick
//   - A shared prescaler runs 0..TICK_DIV-1 and pulses tick for 1 clock at TICK_DIV-1.
//  Decode
//   - Forward sequence is 1-3-2-6-4-5-1.
//   - When the debounced state S differs from the accepted state A (one clock compare):
//     - S in {0,7}: err+=1; A unchanged.
//     - A==0 (first after reset): A<=S; no edge.
//     - S is the next state after A: forward edge, dir=+1, position+=1.
//     - S is the previous state before A: reverse edge, dir=-1, position-=1.
//     - Any other S: err+=1; A<=S; period counter<=0; no period update.
//   - err saturates at 2**32-1.
//   - position is signed 32-bit and wraps in two's complement.
//  Period (per wheel)
//   - cnt+=1 on tick; cnt saturates at TIMEOUT_TICKS.
//   - On a valid edge:
//     - if stall=0: period<=cnt+tick (the same-cycle tick is counted).
//     - if stall=1: period is kept; stall<=0.
//     - in both cases cnt<=0.
//   - The first edge after stall or reset therefore gives no period (partial
//     interval); a valid period appears from the 2nd edge on.
//   - When cnt reaches TIMEOUT_TICKS: stall<=1, period<=0.
//   - An edge in the same cycle as timeout: the edge wins.
//  Avalon read (one wait state)
//   - Cycle 0 of a read: waitrequest=1; readdata is registered from address.
//   - Cycle 1: waitrequest=0; data is valid; read completes.
//   - A read held longer repeats this 2-cycle pattern.
//   - Register map (reg = address[15:8]):
//     - 0x00 period (zero-extended)
//     - 0x01 {29'b0, A}
//     - 0x02 dir (signed -1/0/+1)
//     - 0x03 position
//     - 0x04 err
//     - 0x05 {31'b0, stall}
//   - Undefined reg or wheel >= NUMBER_OF_WHEELS: 32'hDEADBEEF.
//  Avalon write (zero wait states)
//   - 0x03: position<=writedata.
//   - 0x04: err<=0 (data ignored).
//   - All other writes and any wheel >= NUMBER_OF_WHEELS: ignored.
//   - A write in the same cycle as an edge on the same register: the write wins.
//  Reset mid-operation: all state clears immediately; no partial period is kept.
// TESTING
//  - Reset: hold reset_n=0, then release -> stall=1; reading reg 0x00..0x05 gives
//    0,0,0,0,0,1; reading reg 0x07 gives DEADBEEF.
//  - Forward: TICK_DIV=50, hall steps 1,3,2,6 every 1000 clocks -> period=20
//    after the 3rd step, dir=+1, position=3, stall=0.
//  - Reverse + wrap: write position=0x7FFFFFFF, then hall 6->2 -> position=0x7FFFFFFE,
//    dir=-1; a write in the same cycle as an edge keeps the write value.
//  - Glitch/illegal: 5-clock pulse on h1 -> no change; hall=7 held -> err=1;
//    jump 1->6 -> err=2, no period update; write reg 0x04 -> err=0.
//  - Stall: no edges for TIMEOUT_TICKS -> stall=1, period=0; next edge -> stall=0,
//    period stays 0; following edge -> period valid.
//  - Multi-wheel: NUMBER_OF_WHEELS=3, drive wheel 2 only -> wheels 0/1 unchanged;
//    address 0x0303 -> DEADBEEF; every read shows exactly 1 waitrequest cycle.

Source files
------------

// File: rtl/hall_speed_meter.sv
// hall_speed_meter: per-wheel 3-phase hall commutation decoder measuring direction,
// signed position, commutation period, stall and error count behind an Avalon-MM slave.
module hall_speed_meter #(
  parameter int unsigned CLOCK_SPEED_HZ   = 50_000_000,
  parameter int unsigned NUMBER_OF_WHEELS = 1,
  parameter int unsigned TICK_DIV         = 50,
  parameter int unsigned PERIOD_WIDTH     = 24,
  parameter int unsigned TIMEOUT_TICKS    = 1_000_000,
  parameter int unsigned DEBOUNCE_CYCLES  = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [3*NUMBER_OF_WHEELS-1:0] hall,
  input  logic [15:0]                   address,
  input  logic                          read,
  input  logic                          write,
  input  logic [31:0]                   writedata,
  output logic [31:0]                   readdata,
  output logic                          waitrequest,
  output logic [NUMBER_OF_WHEELS-1:0]   stall
);

  localparam int unsigned NW  = NUMBER_OF_WHEELS;
  localparam int unsigned HW  = 3 * NUMBER_OF_WHEELS;
  localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PRW = PERIOD_WIDTH;
  localparam logic [PRW-1:0] TIMEOUT = PRW'(TIMEOUT_TICKS);

  localparam logic [7:0] REG_PERIOD   = 8'h00;
  localparam logic [7:0] REG_STATE    = 8'h01;
  localparam logic [7:0] REG_DIR      = 8'h02;
  localparam logic [7:0] REG_POSITION = 8'h03;
  localparam logic [7:0] REG_ERR      = 8'h04;
  localparam logic [7:0] REG_STALL    = 8'h05;
  localparam logic [31:0] RD_INVALID  = 32'hDEAD_BEEF;

  // Elaboration-time parameter sanity
  if (TICK_DIV == 0 || CLOCK_SPEED_HZ < TICK_DIV) begin : g_bad_tick
    $error("hall_speed_meter: TICK_DIV must be within 1..CLOCK_SPEED_HZ");
  end
  if (NUMBER_OF_WHEELS < 1 || NUMBER_OF_WHEELS > 255) begin : g_bad_wheels
    $error("hall_speed_meter: NUMBER_OF_WHEELS must be within 1..255");
  end
  if (PERIOD_WIDTH < 32 && TIMEOUT_TICKS >= (64'd1 << PERIOD_WIDTH)) begin : g_bad_timeout
    $error("hall_speed_meter: TIMEOUT_TICKS must fit in PERIOD_WIDTH");
  end

  logic [HW-1:0]   sync1_q, sync1_d, sync2_q, sync2_d, deb_q, deb_d;
  logic [DCW-1:0]  dcnt_q [HW];
  logic [DCW-1:0]  dcnt_d [HW];
  logic [PSW-1:0]  presc_q, presc_d;
  logic            tick_c;

  logic [2:0]      acc_q  [NW];
  logic [2:0]      acc_d  [NW];
  logic [1:0]      dir_q  [NW];
  logic [1:0]      dir_d  [NW];
  logic [31:0]     pos_q  [NW];
  logic [31:0]     pos_d  [NW];
  logic [31:0]     err_q  [NW];
  logic [31:0]     err_d  [NW];
  logic [PRW-1:0]  cnt_q  [NW];
  logic [PRW-1:0]  cnt_d  [NW];
  logic [PRW-1:0]  per_q  [NW];
  logic [PRW-1:0]  per_d  [NW];
  logic [NW-1:0]   stall_q, stall_d, bad_q, bad_d;

  logic            rd_phase_q, rd_phase_d;
  logic [31:0]     rdata_q, rdata_d, rd_mux_c;

  function automatic logic [2:0] fwd_of(input logic [2:0] s);
    case (s)
      3'd1:    fwd_of = 3'd3;
      3'd3:    fwd_of = 3'd2;
      3'd2:    fwd_of = 3'd6;
      3'd6:    fwd_of = 3'd4;
      3'd4:    fwd_of = 3'd5;
      3'd5:    fwd_of = 3'd1;
      default: fwd_of = 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] rev_of(input logic [2:0] s);
    case (s)
      3'd3:    rev_of = 3'd1;
      3'd2:    rev_of = 3'd3;
      3'd6:    rev_of = 3'd2;
      3'd4:    rev_of = 3'd6;
      3'd5:    rev_of = 3'd4;
      3'd1:    rev_of = 3'd5;
      default: rev_of = 3'd0;
    endcase
  endfunction

  // Synchronizer, per-bit debounce and the shared tick prescaler
  always_comb begin
    sync1_d = hall;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int i = 0; i < int'(HW); i++) begin
      dcnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DCW'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DCW'(1);
        end
      end
    end
    tick_c  = (presc_q == PSW'(TICK_DIV - 1));
    presc_d = tick_c ? '0 : presc_q + PSW'(1);
  end

  // Per-wheel commutation decode, period/stall timing and register writes
  always_comb begin
    logic [2:0]     st_c;
    logic           fwd_c;
    logic           rev_c;
    logic [PRW-1:0] cnt_inc_c;
    st_c      = '0;
    fwd_c     = 1'b0;
    rev_c     = 1'b0;
    cnt_inc_c = '0;
    stall_d   = stall_q;
    bad_d     = '0;
    for (int w = 0; w < int'(NW); w++) begin
      acc_d[w]  = acc_q[w];
      dir_d[w]  = dir_q[w];
      pos_d[w]  = pos_q[w];
      err_d[w]  = err_q[w];
      per_d[w]  = per_q[w];
      st_c      = deb_q[3*w +: 3];
      fwd_c     = 1'b0;
      rev_c     = 1'b0;
      cnt_inc_c = (tick_c && cnt_q[w] != TIMEOUT) ? cnt_q[w] + PRW'(1) : cnt_q[w];
      cnt_d[w]  = cnt_inc_c;

      if (st_c != acc_q[w]) begin
        if (st_c == 3'd0 || st_c == 3'd7) begin
          // Count an illegal code once per occurrence, not once per clock it is held
          bad_d[w] = 1'b1;
          if (!bad_q[w] && err_q[w] != '1) err_d[w] = err_q[w] + 32'd1;
        end else if (acc_q[w] == 3'd0) begin
          acc_d[w] = st_c;
        end else if (st_c == fwd_of(acc_q[w])) begin
          fwd_c = 1'b1;
        end else if (st_c == rev_of(acc_q[w])) begin
          rev_c = 1'b1;
        end else begin
          if (err_q[w] != '1) err_d[w] = err_q[w] + 32'd1;
          acc_d[w] = st_c;
          cnt_d[w] = '0;
        end
      end

      if (fwd_c || rev_c) begin
        acc_d[w] = st_c;
        dir_d[w] = fwd_c ? 2'b01 : 2'b11;
        pos_d[w] = fwd_c ? pos_q[w] + 32'd1 : pos_q[w] - 32'd1;
        if (!stall_q[w]) per_d[w] = cnt_inc_c;
        stall_d[w] = 1'b0;
        cnt_d[w]   = '0;
      end else if (cnt_q[w] == TIMEOUT) begin
        stall_d[w] = 1'b1;
        per_d[w]   = '0;
      end

      if (write && address[7:0] == 8'(w)) begin
        if (address[15:8] == REG_POSITION) pos_d[w] = writedata;
        if (address[15:8] == REG_ERR)      err_d[w] = '0;
      end
    end
  end

  // Read mux; the wheel loop leaves the invalid marker for out-of-range wheels
  always_comb begin
    rd_mux_c = RD_INVALID;
    for (int w = 0; w < int'(NW); w++) begin
      if (address[7:0] == 8'(w)) begin
        case (address[15:8])
          REG_PERIOD:   rd_mux_c = 32'(per_q[w]);
          REG_STATE:    rd_mux_c = {29'd0, acc_q[w]};
          REG_DIR:      rd_mux_c = {{30{dir_q[w][1]}}, dir_q[w]};
          REG_POSITION: rd_mux_c = pos_q[w];
          REG_ERR:      rd_mux_c = err_q[w];
          REG_STALL:    rd_mux_c = {31'd0, stall_q[w]};
          default:      rd_mux_c = RD_INVALID;
        endcase
      end
    end
  end

  // One wait state per read: capture in phase 0, present in phase 1
  always_comb begin
    rd_phase_d = read && !rd_phase_q;
    rdata_d    = rdata_q;
    if (read && !rd_phase_q) rdata_d = rd_mux_c;
  end

  assign waitrequest = read && !rd_phase_q;
  assign readdata    = rdata_q;
  assign stall       = stall_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      presc_q    <= '0;
      stall_q    <= '1;
      bad_q      <= '0;
      rd_phase_q <= 1'b0;
      rdata_q    <= '0;
      for (int i = 0; i < int'(HW); i++) dcnt_q[i] <= '0;
      for (int w = 0; w < int'(NW); w++) begin
        acc_q[w] <= '0;
        dir_q[w] <= '0;
        pos_q[w] <= '0;
        err_q[w] <= '0;
        cnt_q[w] <= '0;
        per_q[w] <= '0;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      dcnt_q     <= dcnt_d;
      presc_q    <= presc_d;
      stall_q    <= stall_d;
      bad_q      <= bad_d;
      rd_phase_q <= rd_phase_d;
      rdata_q    <= rdata_d;
      acc_q      <= acc_d;
      dir_q      <= dir_d;
      pos_q      <= pos_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      per_q      <= per_d;
    end
  end

endmodule

// File: tb/tb_hall_speed_meter.sv
// Bench for hall_speed_meter: directed wheel-0 scenarios, then a randomized walk on
// wheel 2 checked against an event-level model of position, direction, errors and period.
module tb_hall_speed_meter;

  localparam int unsigned NW = 3;
  localparam int unsigned TD = 50;
  localparam int unsigned TO = 100;
  localparam logic [31:0] BAD = 32'hDEADBEEF;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [3*NW-1:0] hall;
  logic [15:0]     address;
  logic            read;
  logic            write;
  logic [31:0]     writedata;
  logic [31:0]     readdata;
  logic            waitrequest;
  logic [NW-1:0]   stall;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  logic [2:0]  seq [6] = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd4, 3'd5};

  hall_speed_meter #(
    .CLOCK_SPEED_HZ  (50_000_000),
    .NUMBER_OF_WHEELS(NW),
    .TICK_DIV        (TD),
    .PERIOD_WIDTH    (24),
    .TIMEOUT_TICKS   (TO),
    .DEBOUNCE_CYCLES (16)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .hall       (hall),
    .address    (address),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .waitrequest(waitrequest),
    .stall      (stall)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_to(input int unsigned t);
    while (cyc < t) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_hall(input int w, input logic [2:0] v);
    hall[3*w +: 3] = v;
  endtask

  task automatic chk_reg(input string tag, input logic [7:0] r, input logic [7:0] w,
                         input logic [31:0] exp);
    logic [31:0] d;
    address = {r, w};
    read    = 1'b1;
    #1;
    check({tag, "_wait0"}, 32'(waitrequest), 32'd1);
    @(posedge clock);
    #1;
    check({tag, "_wait1"}, 32'(waitrequest), 32'd0);
    d       = readdata;
    read    = 1'b0;
    address = '0;
    check(tag, d, exp);
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] r, input logic [7:0] w, input logic [31:0] d);
    address   = {r, w};
    writedata = d;
    write     = 1'b1;
    @(posedge clock);
    #1;
    write   = 1'b0;
    address = '0;
  endtask

  initial begin : main
    int unsigned t, tn, last, k, r, idx;
    logic [31:0] m_pos, m_dir, m_err, m_per;
    logic [2:0]  m_a;
    logic        m_stall;

    reset_n = 1'b0; hall = '0; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    repeat (4) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Reset state
    check("rst_stall_port", 32'(stall), 32'h7);
    chk_reg("rst_period", 8'h00, 8'd0, 32'd0);
    chk_reg("rst_state",  8'h01, 8'd0, 32'd0);
    chk_reg("rst_dir",    8'h02, 8'd0, 32'd0);
    chk_reg("rst_pos",    8'h03, 8'd0, 32'd0);
    chk_reg("rst_err",    8'h04, 8'd0, 32'd0);
    chk_reg("rst_stall",  8'h05, 8'd0, 32'd1);
    chk_reg("rst_undef",  8'h07, 8'd0, BAD);

    // Forward 1-3-2-6, 1000 clocks (20 ticks) apart
    t = cyc + 10;
    wait_to(t);        set_hall(0, 3'd1);
    wait_to(t + 1000); set_hall(0, 3'd3);
    wait_to(t + 2000); set_hall(0, 3'd2);
    wait_to(t + 2040);
    chk_reg("fwd_period_3rd", 8'h00, 8'd0, 32'd20);
    wait_to(t + 3000); set_hall(0, 3'd6);
    wait_to(t + 3040);
    chk_reg("fwd_period", 8'h00, 8'd0, 32'd20);
    chk_reg("fwd_dir",    8'h02, 8'd0, 32'd1);
    chk_reg("fwd_pos",    8'h03, 8'd0, 32'd3);
    chk_reg("fwd_state",  8'h01, 8'd0, 32'd6);
    chk_reg("fwd_stall",  8'h05, 8'd0, 32'd0);
    check("fwd_stall_port", 32'(stall[0]), 32'd0);

    // Reverse, write/edge collision, negative wrap
    wr(8'h03, 8'd0, 32'h7FFFFFFF);
    wait_to(t + 4000); set_hall(0, 3'd2);
    wait_to(t + 4040);
    chk_reg("rev_pos",    8'h03, 8'd0, 32'h7FFFFFFE);
    chk_reg("rev_dir",    8'h02, 8'd0, 32'hFFFFFFFF);
    chk_reg("rev_period", 8'h00, 8'd0, 32'd20);
    wait_to(t + 5000); set_hall(0, 3'd3);
    wait_to(t + 5018); wr(8'h03, 8'd0, 32'h12345678);
    wait_to(t + 5040);
    chk_reg("coll_pos",   8'h03, 8'd0, 32'h12345678);
    chk_reg("coll_state", 8'h01, 8'd0, 32'd3);
    chk_reg("coll_dir",   8'h02, 8'd0, 32'hFFFFFFFF);
    wr(8'h03, 8'd0, 32'h80000000);
    wait_to(t + 6000); set_hall(0, 3'd1);
    wait_to(t + 6040);
    chk_reg("wrap_pos",   8'h03, 8'd0, 32'h7FFFFFFF);

    // Glitch, held illegal code, illegal jump, error clear
    wait_to(t + 6100); set_hall(0, 3'd0);
    wait_to(t + 6105); set_hall(0, 3'd1);
    wait_to(t + 6150);
    chk_reg("glitch_err",   8'h04, 8'd0, 32'd0);
    chk_reg("glitch_state", 8'h01, 8'd0, 32'd1);
    chk_reg("glitch_pos",   8'h03, 8'd0, 32'h7FFFFFFF);
    wait_to(t + 6200); set_hall(0, 3'd7);
    wait_to(t + 6260);
    chk_reg("seven_err",    8'h04, 8'd0, 32'd1);
    chk_reg("seven_state",  8'h01, 8'd0, 32'd1);
    wait_to(t + 6300); set_hall(0, 3'd1);
    wait_to(t + 6400); set_hall(0, 3'd6);
    wait_to(t + 6440);
    chk_reg("jump_err",     8'h04, 8'd0, 32'd2);
    chk_reg("jump_state",   8'h01, 8'd0, 32'd6);
    chk_reg("jump_period",  8'h00, 8'd0, 32'd20);
    chk_reg("jump_pos",     8'h03, 8'd0, 32'h7FFFFFFF);
    wr(8'h04, 8'd0, 32'h5555AAAA);
    chk_reg("err_clear",    8'h04, 8'd0, 32'd0);

    // Stall after TIMEOUT_TICKS without an edge, then recovery
    wait_to(t + 6400 + TO * TD + 300);
    chk_reg("stall_flag",   8'h05, 8'd0, 32'd1);
    chk_reg("stall_period", 8'h00, 8'd0, 32'd0);
    check("stall_port", 32'(stall[0]), 32'd1);
    wait_to(t + 11800); set_hall(0, 3'd4);
    wait_to(t + 11840);
    chk_reg("unstall_flag",   8'h05, 8'd0, 32'd0);
    chk_reg("unstall_period", 8'h00, 8'd0, 32'd0);
    chk_reg("unstall_pos",    8'h03, 8'd0, 32'h80000000);
    wait_to(t + 12800); set_hall(0, 3'd5);
    wait_to(t + 12840);
    chk_reg("second_period",  8'h00, 8'd0, 32'd20);
    chk_reg("second_pos",     8'h03, 8'd0, 32'h80000001);

    // Randomized walk on wheel 2 against the event-level model
    tn   = t + 13000;
    idx  = $urandom_range(0, 5);
    wait_to(tn); set_hall(2, seq[idx]);
    m_a = seq[idx]; m_stall = 1'b1; m_per = '0; m_pos = '0; m_dir = '0; m_err = '0;
    last = tn;
    wait_to(tn + 40);
    chk_reg("w2_init_state", 8'h01, 8'd2, 32'(m_a));
    chk_reg("w2_init_pos",   8'h03, 8'd2, 32'd0);
    repeat (25) begin
      k  = $urandom_range(3, 30);
      r  = $urandom_range(0, 9);
      tn = tn + k * TD;
      if (r < 9) begin
        idx = (r < 6) ? (idx + 1) % 6 : (idx + 5) % 6;
        if (!m_stall) m_per = 32'((tn - last) / TD);
        m_stall = 1'b0;
        m_pos   = (r < 6) ? m_pos + 32'd1 : m_pos - 32'd1;
        m_dir   = (r < 6) ? 32'd1 : 32'hFFFFFFFF;
      end else begin
        idx   = (idx + 2 + $urandom_range(0, 2)) % 6;
        m_err = m_err + 32'd1;
      end
      last = tn;
      m_a  = seq[idx];
      wait_to(tn); set_hall(2, m_a);
      wait_to(tn + 40);
      chk_reg("w2_state",  8'h01, 8'd2, 32'(m_a));
      chk_reg("w2_pos",    8'h03, 8'd2, m_pos);
      chk_reg("w2_dir",    8'h02, 8'd2, m_dir);
      chk_reg("w2_err",    8'h04, 8'd2, m_err);
      chk_reg("w2_period", 8'h00, 8'd2, m_per);
      check("w2_stall_port", 32'(stall[2]), 32'(m_stall));
    end

    // Isolation, ignored writes, out-of-range wheel, final timeout on all wheels
    wr(8'h03, 8'd3, 32'hCAFEF00D);
    wr(8'h02, 8'd1, 32'h00000001);
    wait_to(tn + TO * TD + 400);
    chk_reg("w0_state",  8'h01, 8'd0, 32'd5);
    chk_reg("w0_pos",    8'h03, 8'd0, 32'h80000001);
    chk_reg("w0_err",    8'h04, 8'd0, 32'd0);
    chk_reg("w0_period", 8'h00, 8'd0, 32'd0);
    chk_reg("w1_period", 8'h00, 8'd1, 32'd0);
    chk_reg("w1_state",  8'h01, 8'd1, 32'd0);
    chk_reg("w1_dir",    8'h02, 8'd1, 32'd0);
    chk_reg("w1_pos",    8'h03, 8'd1, 32'd0);
    chk_reg("w1_err",    8'h04, 8'd1, 32'd0);
    chk_reg("w1_stall",  8'h05, 8'd1, 32'd1);
    chk_reg("w2_final_pos",    8'h03, 8'd2, m_pos);
    chk_reg("w2_final_period", 8'h00, 8'd2, 32'd0);
    check("all_stall_port", 32'(stall), 32'h7);
    chk_reg("bad_wheel", 8'h03, 8'd3, BAD);
    chk_reg("bad_reg",   8'h06, 8'd0, BAD);

    // Reset mid-operation clears everything at once
    reset_n = 1'b0;
    #1;
    check("midrst_stall_port", 32'(stall), 32'h7);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    chk_reg("midrst_pos", 8'h03, 8'd0, 32'd0);
    chk_reg("midrst_err", 8'h04, 8'd2, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
